mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between instruction fetch (IF, read-only) and the MEM stage (DM, read/write).
- Sequences each access: issue, fixed read latency, then completion.
- Drives if_stall/dm_stall into pipeline hazard control; that control freezes the pipeline while either access is pending.
- Non-pipelined: at most one access in flight. DM has fixed priority over IF.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and SRAM-side signals of the shared memory port.
// slave:  the arbiter's view (requests and SRAM read data in, completions and SRAM controls out).
// master: the pipeline/SRAM side of the same wires.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
);
    // Instruction fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    // Data (MEM stage) port
    logic              dm_req;
    logic [3:0]        dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              dm_stall;

    // Single-port SRAM
    logic              mem_cs;
    logic              mem_oe;
    logic [3:0]        mem_web;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_di;
    logic [DATA_W-1:0] mem_do;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_do,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
        output mem_cs, mem_oe, mem_web, mem_addr, mem_di
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_do,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
        input  mem_cs, mem_oe, mem_web, mem_addr, mem_di
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous SRAM between instruction fetch (read-only)
// and the MEM stage (read/write). One access in flight at a time; DM has fixed priority.
// Each access: issue in IDLE, READ_LAT wait cycles for reads, one DONE cycle for the pulse.
// READ_LAT legal range is 1..4.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 1
) (
    input logic            clk,
    input logic            rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IF   = 2'd1;
    localparam logic [1:0] GNT_DM   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic              issue_cs;
    logic              issue_oe;
    logic [3:0]        issue_web;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_di;

    // Next-state logic and combinational SRAM issue, which only ever happens in IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        issue_cs   = 1'b0;
        issue_oe   = 1'b0;
        issue_web  = 4'hF;
        issue_addr = '0;
        issue_di   = '0;

        case (state_q)
            IDLE: begin
                gnt_d = GNT_NONE;
                // No issue while reset is held, so the SRAM stays quiet during reset.
                if (rst) begin
                    if (bus.dm_req) begin
                        gnt_d      = GNT_DM;
                        issue_cs   = 1'b1;
                        issue_addr = bus.dm_addr;
                        issue_di   = bus.dm_wdata;
                        if (bus.dm_we != 4'b0000) begin
                            issue_web = ~bus.dm_we;
                            state_d   = DONE;
                        end else begin
                            issue_oe = 1'b1;
                            cnt_d    = 3'(READ_LAT);
                            state_d  = RD_WAIT;
                        end
                    end else if (bus.if_req) begin
                        gnt_d      = GNT_IF;
                        issue_cs   = 1'b1;
                        issue_oe   = 1'b1;
                        issue_addr = bus.if_addr;
                        cnt_d      = 3'(READ_LAT);
                        state_d    = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                    // A withdrawn (flushed) request leaves its rdata untouched.
                    if (gnt_q == GNT_IF && bus.if_req) begin
                        if_rdata_d = bus.mem_do;
                    end
                    if (gnt_q == GNT_DM && bus.dm_req) begin
                        dm_rdata_d = bus.mem_do;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; an in-flight read is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            gnt_q      <= GNT_NONE;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.mem_cs   = issue_cs;
    assign bus.mem_oe   = issue_oe;
    assign bus.mem_web  = issue_web;
    assign bus.mem_addr = issue_addr;
    assign bus.mem_di   = issue_di;

    // Completion pulses only for a requester that is still asking; stalls drop with the pulse.
    assign bus.if_valid = (state_q == DONE) && (gnt_q == GNT_IF) && bus.if_req;
    assign bus.dm_valid = (state_q == DONE) && (gnt_q == GNT_DM) && bus.dm_req;
    assign bus.if_stall = bus.if_req & ~bus.if_valid;
    assign bus.dm_stall = bus.dm_req & ~bus.dm_valid;

    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_rdata = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at READ_LAT=1, one at READ_LAT=3, each
// with a behavioural SRAM. Read results are queued when requested and checked at the pulse.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus3 ();

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .READ_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .READ_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int a);
        if (a == 16)  return 32'h00A00093;
        if (a == 256) return 32'hDEADBEEF;
        return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    // Behavioural SRAMs (512 words are enough for the addresses used here).
    logic [31:0] sram1 [0:511];
    logic [31:0] sram3 [0:511];
    logic [31:0] rd1;
    logic [31:0] rd3 [0:2];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 512; i++) sram1[i] <= init_word(i);
        end else if (bus1.mem_cs) begin
            if (bus1.mem_oe) rd1 <= sram1[bus1.mem_addr[8:0]];
            for (int b = 0; b < 4; b++)
                if (!bus1.mem_web[b]) sram1[bus1.mem_addr[8:0]][8*b +: 8] <= bus1.mem_di[8*b +: 8];
        end
    end
    assign bus1.mem_do = rd1;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 512; i++) sram3[i] <= init_word(i);
        end else if (bus3.mem_cs && bus3.mem_oe) begin
            rd3[0] <= sram3[bus3.mem_addr[8:0]];
        end
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign bus3.mem_do = rd3[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected read data per requester, popped at each completion pulse.
    logic [31:0] exp_if_q [$];
    logic [31:0] exp_dm_q [$];
    logic [31:0] exp_dm3_q [$];

    always @(negedge clk) begin
        if (bus1.if_valid === 1'b1) begin
            if (exp_if_q.size() == 0) check("if_unexpected_valid", 32'(bus1.if_valid), 32'd0);
            else check("if_rdata", bus1.if_rdata, exp_if_q.pop_front());
        end
        if (bus1.dm_valid === 1'b1) begin
            if (exp_dm_q.size() == 0) check("dm_unexpected_valid", 32'(bus1.dm_valid), 32'd0);
            else check("dm_rdata", bus1.dm_rdata, exp_dm_q.pop_front());
        end
        if (bus3.dm_valid === 1'b1) begin
            if (exp_dm3_q.size() == 0) check("dm3_unexpected_valid", 32'(bus3.dm_valid), 32'd0);
            else check("dm3_rdata", bus3.dm_rdata, exp_dm3_q.pop_front());
        end
        if (bus3.if_valid === 1'b1) check("if3_unexpected_valid", 32'(bus3.if_valid), 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] ref_mem [0:511];
    logic [31:0] old_if;
    int          cs_count;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.dm_req = 1'b0; bus1.dm_we = 4'b0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
        bus3.if_req = 1'b0; bus3.if_addr = '0;
        bus3.dm_req = 1'b0; bus3.dm_we = 4'b0; bus3.dm_addr = '0; bus3.dm_wdata = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);

        // Reset state
        repeat (3) step();
        sample();
        check("rst_if_valid", 32'(bus1.if_valid), 32'd0);
        check("rst_dm_valid", 32'(bus1.dm_valid), 32'd0);
        check("rst_if_rdata", bus1.if_rdata, 32'd0);
        check("rst_dm_rdata", bus1.dm_rdata, 32'd0);
        check("rst_mem_cs", 32'(bus1.mem_cs), 32'd0);
        check("rst_mem_oe", 32'(bus1.mem_oe), 32'd0);
        check("rst_mem_web", 32'(bus1.mem_web), 32'hF);
        check("rst_mem_addr", 32'(bus1.mem_addr), 32'd0);
        check("rst_mem_di", bus1.mem_di, 32'd0);
        check("rst3_mem_web", 32'(bus3.mem_web), 32'hF);
        step(); rst = 1'b1;
        step();

        // IF read of 0x010, READ_LAT=1: issue c0, pulse c2
        step(); bus1.if_req = 1'b1; bus1.if_addr = 14'h010; exp_if_q.push_back(ref_mem[16]);
        sample();
        check("t1_c0_cs", 32'(bus1.mem_cs), 32'd1);
        check("t1_c0_oe", 32'(bus1.mem_oe), 32'd1);
        check("t1_c0_addr", 32'(bus1.mem_addr), 32'h010);
        check("t1_c0_stall", 32'(bus1.if_stall), 32'd1);
        step(); sample();
        check("t1_c1_cs", 32'(bus1.mem_cs), 32'd0);
        check("t1_c1_stall", 32'(bus1.if_stall), 32'd1);
        check("t1_c1_valid", 32'(bus1.if_valid), 32'd0);
        step(); sample();
        check("t1_c2_valid", 32'(bus1.if_valid), 32'd1);
        check("t1_c2_stall", 32'(bus1.if_stall), 32'd0);
        check("t1_c2_cs", 32'(bus1.mem_cs), 32'd0);
        step(); bus1.if_req = 1'b0;
        step();

        // Simultaneous IF (0x004) and DM read (0x100): DM first
        step();
        bus1.if_req = 1'b1; bus1.if_addr = 14'h004; exp_if_q.push_back(ref_mem[4]);
        bus1.dm_req = 1'b1; bus1.dm_we = 4'b0; bus1.dm_addr = 14'h100;
        exp_dm_q.push_back(ref_mem[256]);
        sample();
        check("t2_c0_addr", 32'(bus1.mem_addr), 32'h100);
        check("t2_c0_cs", 32'(bus1.mem_cs), 32'd1);
        check("t2_c0_dm_stall", 32'(bus1.dm_stall), 32'd1);
        step(); sample();
        check("t2_c1_if_stall", 32'(bus1.if_stall), 32'd1);
        step(); sample();
        check("t2_c2_dm_valid", 32'(bus1.dm_valid), 32'd1);
        check("t2_c2_dm_stall", 32'(bus1.dm_stall), 32'd0);
        check("t2_c2_if_stall", 32'(bus1.if_stall), 32'd1);
        step(); bus1.dm_req = 1'b0;
        sample();
        check("t2_c3_cs", 32'(bus1.mem_cs), 32'd1);
        check("t2_c3_addr", 32'(bus1.mem_addr), 32'h004);
        check("t2_c3_if_stall", 32'(bus1.if_stall), 32'd1);
        step(); sample();
        check("t2_c4_if_stall", 32'(bus1.if_stall), 32'd1);
        check("t2_c4_if_valid", 32'(bus1.if_valid), 32'd0);
        step(); sample();
        check("t2_c5_if_valid", 32'(bus1.if_valid), 32'd1);
        check("t2_c5_if_stall", 32'(bus1.if_stall), 32'd0);
        step(); bus1.if_req = 1'b0;
        step();

        // Half-word store to 0x020, then read it back; dm_rdata holds across the write
        step();
        bus1.dm_req = 1'b1; bus1.dm_we = 4'b0011; bus1.dm_addr = 14'h020;
        bus1.dm_wdata = 32'h12345678;
        ref_mem[32] = {ref_mem[32][31:16], 16'h5678};
        exp_dm_q.push_back(ref_mem[256]);
        sample();
        check("t3_c0_web", 32'(bus1.mem_web), 32'hC);
        check("t3_c0_oe", 32'(bus1.mem_oe), 32'd0);
        check("t3_c0_di", bus1.mem_di, 32'h12345678);
        step(); sample();
        check("t3_c1_dm_valid", 32'(bus1.dm_valid), 32'd1);
        step(); bus1.dm_req = 1'b0; bus1.dm_we = 4'b0;
        step();
        bus1.dm_req = 1'b1; bus1.dm_addr = 14'h020; exp_dm_q.push_back(ref_mem[32]);
        step(); step(); sample();
        check("t3_rb_valid", 32'(bus1.dm_valid), 32'd1);
        check("t3_rb_upper", 32'(bus1.dm_rdata[31:16]), 32'(init_word(32) >> 16));
        step(); bus1.dm_req = 1'b0;
        step();

        // READ_LAT=3 DM read: one issue cycle, pulse at c4, no re-issue in DONE
        step(); bus3.dm_req = 1'b1; bus3.dm_addr = 14'h100; exp_dm3_q.push_back(ref_mem[256]);
        cs_count = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) step();
            sample();
            cs_count += int'(bus3.mem_cs);
            check($sformatf("t4_c%0d_cs", c), 32'(bus3.mem_cs), 32'(c == 0));
            check($sformatf("t4_c%0d_valid", c), 32'(bus3.dm_valid), 32'(c == 4));
        end
        check("t4_cs_count", 32'(cs_count), 32'd1);
        step(); bus3.dm_req = 1'b0;
        step();

        // Flush: IF read of 0x030 withdrawn in c1; no pulse, rdata kept, IDLE again at c3
        old_if = ref_mem[4];
        step(); bus1.if_req = 1'b1; bus1.if_addr = 14'h030;
        sample();
        check("t5_c0_cs", 32'(bus1.mem_cs), 32'd1);
        step(); bus1.if_req = 1'b0;
        sample();
        check("t5_c1_valid", 32'(bus1.if_valid), 32'd0);
        check("t5_c1_stall", 32'(bus1.if_stall), 32'd0);
        step(); sample();
        check("t5_c2_valid", 32'(bus1.if_valid), 32'd0);
        check("t5_c2_rdata", bus1.if_rdata, old_if);
        step(); bus1.if_req = 1'b1; bus1.if_addr = 14'h040; exp_if_q.push_back(ref_mem[64]);
        sample();
        check("t5_c3_cs", 32'(bus1.mem_cs), 32'd1);
        check("t5_c3_addr", 32'(bus1.mem_addr), 32'h040);
        step(); step(); sample();
        check("t5_c5_valid", 32'(bus1.if_valid), 32'd1);
        step(); bus1.if_req = 1'b0;
        step();

        // Reset during RD_WAIT: read discarded, no stale pulse afterwards
        step(); bus1.if_req = 1'b1; bus1.if_addr = 14'h050;
        sample();
        check("t6_c0_cs", 32'(bus1.mem_cs), 32'd1);
        step(); rst = 1'b0;
        step(); sample();
        check("t6_c2_cs", 32'(bus1.mem_cs), 32'd0);
        check("t6_c2_web", 32'(bus1.mem_web), 32'hF);
        check("t6_c2_if_valid", 32'(bus1.if_valid), 32'd0);
        check("t6_c2_dm_valid", 32'(bus1.dm_valid), 32'd0);
        check("t6_c2_if_rdata", bus1.if_rdata, 32'd0);
        check("t6_c2_dm_rdata", bus1.dm_rdata, 32'd0);
        step(); rst = 1'b1; bus1.if_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            check($sformatf("t6_post%0d_cs", c), 32'(bus1.mem_cs), 32'd0);
            check($sformatf("t6_post%0d_valid", c), 32'(bus1.if_valid), 32'd0);
            step();
        end
        bus1.if_req = 1'b1; bus1.if_addr = 14'h060; exp_if_q.push_back(ref_mem[96]);
        step(); step(); sample();
        check("t6_new_valid", 32'(bus1.if_valid), 32'd1);
        step(); bus1.if_req = 1'b0;
        repeat (2) step();

        check("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
        check("dm_queue_drained", 32'(exp_dm_q.size()), 32'd0);
        check("dm3_queue_drained", 32'(exp_dm3_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
